triangle_dispatch_ctrl: RTL and testbench

Sequences triangle traffic between the input protocol decoder and the rasterizer. Each decoded triangle (three vertices plus texture number) is captured into a small FWFT queue and acknowledged back to the decoder with a one-cycle next_triangle pulse. Queued triangles are handed to the rasterizer over a valid/ready handshake. At end of frame the block drains the queue, waits for the rasterizer to go idle, and runs a buffer-swap handshake before it accepts the next frame.

---
 rtl/triangle_dispatch_ctrl.sv | 137 +++++++++++++
 tb/tb_triangle_dispatch_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_dispatch_ctrl.sv
// Triangle dispatch controller: buffers decoded triangles in a FWFT queue, hands them
// to the rasterizer over valid/ready, and sequences the end-of-frame drain and buffer swap.
module triangle_dispatch_ctrl #(
    parameter int DEPTH   = 4,
    parameter int COORD_W = 16,
    parameter int TEX_W   = 8,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     data_ready,
    input  logic [COORD_W-1:0]       x1,
    input  logic [COORD_W-1:0]       y1,
    input  logic [COORD_W-1:0]       x2,
    input  logic [COORD_W-1:0]       y2,
    input  logic [COORD_W-1:0]       x3,
    input  logic [COORD_W-1:0]       y3,
    input  logic [TEX_W-1:0]         TexNum,
    input  logic                     frame_ready,
    output logic                     next_triangle,
    output logic                     tri_valid,
    input  logic                     tri_ready,
    output logic [COORD_W-1:0]       tri_x1,
    output logic [COORD_W-1:0]       tri_y1,
    output logic [COORD_W-1:0]       tri_x2,
    output logic [COORD_W-1:0]       tri_y2,
    output logic [COORD_W-1:0]       tri_x3,
    output logic [COORD_W-1:0]       tri_y3,
    output logic [TEX_W-1:0]         tri_tex,
    input  logic                     raster_idle,
    output logic                     swap_req,
    input  logic                     swap_ack,
    output logic                     frame_done,
    output logic [CNT_W-1:0]         frame_tri_count,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int OCC_W   = PTR_W + 1;
    localparam int ENTRY_W = 6 * COORD_W + TEX_W;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        SWAP  = 2'd2
    } state_t;

    state_t             state;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   disp_cnt;
    logic [ENTRY_W-1:0] head;
    logic               capture;
    logic               pop;

    // Capture is suppressed while next_triangle is high so a slow decoder is not sampled twice.
    assign capture = (state == RUN) && data_ready &&
                     (occupancy != OCC_W'(DEPTH)) && !next_triangle;
    assign tri_valid = (occupancy != '0);
    assign pop       = tri_valid && tri_ready;

    // Head data is forced to zero while empty so the outputs are clean after reset.
    assign head = tri_valid ? mem[rd_ptr] : '0;
    assign {tri_x1, tri_y1, tri_x2, tri_y2, tri_x3, tri_y3, tri_tex} = head;

    always_ff @(posedge clk) begin
        if (capture) begin
            mem[wr_ptr] <= {x1, y1, x2, y2, x3, y3, TexNum};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (capture) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({capture, pop})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= RUN;
            next_triangle   <= 1'b0;
            swap_req        <= 1'b0;
            frame_done      <= 1'b0;
            frame_tri_count <= '0;
            disp_cnt        <= '0;
        end else begin
            next_triangle <= capture;
            frame_done    <= 1'b0;
            if (pop && (disp_cnt != '1)) begin
                disp_cnt <= disp_cnt + CNT_W'(1);
            end
            case (state)
                RUN: begin
                    if (frame_ready && !capture) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((occupancy == '0) && raster_idle) begin
                        state    <= SWAP;
                        swap_req <= 1'b1;
                    end
                end
                SWAP: begin
                    // The queue is empty here, so clearing the count cannot lose a pop.
                    if (swap_ack) begin
                        swap_req        <= 1'b0;
                        frame_done      <= 1'b1;
                        frame_tri_count <= disp_cnt;
                        disp_cnt        <= '0;
                        state           <= RUN;
                    end
                end
                default: begin
                    state    <= RUN;
                    swap_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_triangle_dispatch_ctrl.sv
// Scoreboard bench for triangle_dispatch_ctrl: acknowledged triangles are queued as expected
// rasterizer traffic and a negedge monitor checks every handshake against that queue.
module tb_triangle_dispatch_ctrl;

    localparam int DEPTH   = 4;
    localparam int COORD_W = 16;
    localparam int TEX_W   = 8;
    localparam int CNT_W   = 16;
    localparam int TMO     = 200;

    typedef struct packed {
        logic [COORD_W-1:0] x1, y1, x2, y2, x3, y3;
        logic [TEX_W-1:0]   tex;
    } triangle_t;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   data_ready = 1'b0;
    logic [COORD_W-1:0]     x1 = '0, y1 = '0, x2 = '0, y2 = '0, x3 = '0, y3 = '0;
    logic [TEX_W-1:0]       TexNum = '0;
    logic                   frame_ready = 1'b0;
    logic                   next_triangle;
    logic                   tri_valid;
    logic                   tri_ready = 1'b0;
    logic [COORD_W-1:0]     tri_x1, tri_y1, tri_x2, tri_y2, tri_x3, tri_y3;
    logic [TEX_W-1:0]       tri_tex;
    logic                   raster_idle = 1'b0;
    logic                   swap_req;
    logic                   swap_ack = 1'b0;
    logic                   frame_done;
    logic [CNT_W-1:0]       frame_tri_count;
    logic [$clog2(DEPTH):0] occupancy;

    triangle_t sb[$];
    int        n_vectors = 0;
    int        n_miscompares = 0;
    int        model_pops = 0;
    int        ack_count = 0;
    logic      prev_nt = 1'b0;

    triangle_dispatch_ctrl #(
        .DEPTH(DEPTH), .COORD_W(COORD_W), .TEX_W(TEX_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .data_ready(data_ready),
        .x1(x1), .y1(y1), .x2(x2), .y2(y2), .x3(x3), .y3(y3), .TexNum(TexNum),
        .frame_ready(frame_ready), .next_triangle(next_triangle),
        .tri_valid(tri_valid), .tri_ready(tri_ready),
        .tri_x1(tri_x1), .tri_y1(tri_y1), .tri_x2(tri_x2), .tri_y2(tri_y2),
        .tri_x3(tri_x3), .tri_y3(tri_y3), .tri_tex(tri_tex),
        .raster_idle(raster_idle), .swap_req(swap_req), .swap_ack(swap_ack),
        .frame_done(frame_done), .frame_tri_count(frame_tri_count),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input triangle_t t, input logic valid);
        {x1, y1, x2, y2, x3, y3, TexNum} = t;
        data_ready = valid;
    endtask

    function automatic triangle_t randTri();
        triangle_t t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t;
    endfunction

    // Holds data_ready until acknowledged; the triangle becomes expected traffic at the ack.
    task automatic sendTriangle(input triangle_t t);
        int waited = 0;
        applyStimulus(t, 1'b1);
        do begin
            tick(1);
            waited++;
        end while (!next_triangle && waited < TMO);
        if (next_triangle) sb.push_back(t);
        else checkOutput("ack_timeout", next_triangle, 1);
        applyStimulus(t, 1'b0);
    endtask

    task automatic waitEmpty();
        int waited = 0;
        while ((occupancy != 0 || sb.size() != 0) && waited < TMO) begin
            tick(1);
            waited++;
        end
        checkOutput("drain_occupancy", occupancy, 0);
    endtask

    task automatic applyReset(input int n);
        reset = 1'b1;
        sb.delete();
        model_pops = 0;
        prev_nt = 1'b0;
        data_ready = 1'b0;
        frame_ready = 1'b0;
        swap_ack = 1'b0;
        tick(n);
        reset = 1'b0;
    endtask

    // Scoreboard monitor: sampled mid-cycle so the next edge's pop decision is already stable.
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("occupancy", occupancy, sb.size());
            checkOutput("tri_valid", tri_valid, sb.size() != 0);
            if (next_triangle) begin
                checkOutput("ack_pulse_width", prev_nt, 0);
                ack_count++;
            end
            prev_nt = next_triangle;
            if (tri_valid && tri_ready && sb.size() != 0) begin
                triangle_t exp_t;
                triangle_t act_t;
                exp_t = sb.pop_front();
                act_t = {tri_x1, tri_y1, tri_x2, tri_y2, tri_x3, tri_y3, tri_tex};
                checkOutput("head_triangle", act_t, exp_t);
                model_pops++;
            end
            if (frame_done) begin
                checkOutput("frame_tri_count_model", frame_tri_count, model_pops);
                model_pops = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        triangle_t t;
        bit        rand_done;

        applyReset(2);
        checkOutput("rst_next_triangle", next_triangle, 0);
        checkOutput("rst_tri_valid", tri_valid, 0);
        checkOutput("rst_tri_data", {tri_x1, tri_y1, tri_x2, tri_y2, tri_x3, tri_y3, tri_tex}, 0);
        checkOutput("rst_swap_req", swap_req, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        checkOutput("rst_frame_tri_count", frame_tri_count, 0);
        checkOutput("rst_occupancy", occupancy, 0);

        $display("[TB] single triangle pass-through");
        tri_ready = 1'b1;
        t = '{x1: 10, y1: 20, x2: 30, y2: 40, x3: 50, y3: 60, tex: 7};
        sendTriangle(t);
        checkOutput("single_valid_after_capture", tri_valid, 1);
        tick(1);
        checkOutput("single_ack_once", next_triangle, 0);
        checkOutput("single_valid_once", tri_valid, 0);
        checkOutput("single_occ_empty", occupancy, 0);

        $display("[TB] back-pressure with full queue");
        tri_ready = 1'b0;
        ack_count = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) sendTriangle(randTri());
            end
            begin
                tick(20);
                checkOutput("full_ack_count", ack_count, DEPTH);
                checkOutput("full_occupancy", occupancy, DEPTH);
                tri_ready = 1'b1;
            end
        join
        waitEmpty();
        checkOutput("full_total_acks", ack_count, 6);

        $display("[TB] simultaneous push and pop");
        tri_ready = 1'b0;
        sendTriangle(randTri());
        sendTriangle(randTri());
        tick(1);
        tri_ready = 1'b1;
        fork
            sendTriangle(randTri());
            begin
                tick(1);
                tri_ready = 1'b0;
                checkOutput("push_pop_occupancy", occupancy, 2);
            end
        join
        tri_ready = 1'b1;
        waitEmpty();

        $display("[TB] randomized traffic");
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    tick($urandom_range(0, 2));
                    sendTriangle(randTri());
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    tri_ready = ($urandom_range(0, 2) != 0);
                    tick(1);
                end
            end
        join
        tri_ready = 1'b1;
        waitEmpty();

        $display("[TB] frame drain waits for raster idle");
        applyReset(1);
        raster_idle = 1'b0;
        for (int i = 0; i < 3; i++) sendTriangle(randTri());
        frame_ready = 1'b1;
        waitEmpty();
        for (int i = 0; i < 5; i++) begin
            tick(1);
            checkOutput("drain_no_swap_busy", swap_req, 0);
        end
        raster_idle = 1'b1;
        tick(1);
        checkOutput("drain_swap_req", swap_req, 1);
        frame_ready = 1'b0;
        tick(5);
        checkOutput("swap_req_held", swap_req, 1);
        swap_ack = 1'b1;
        tick(1);
        swap_ack = 1'b0;
        checkOutput("frame_done_pulse", frame_done, 1);
        checkOutput("swap_req_dropped", swap_req, 0);
        checkOutput("frame_tri_count_3", frame_tri_count, 3);
        tick(1);
        checkOutput("frame_done_once", frame_done, 0);
        sendTriangle(randTri());
        waitEmpty();

        $display("[TB] stray swap_ack and empty frame");
        applyReset(1);
        raster_idle = 1'b1;
        swap_ack = 1'b1;
        tick(1);
        swap_ack = 1'b0;
        checkOutput("stray_ack_no_done", frame_done, 0);
        frame_ready = 1'b1;
        tick(1);
        checkOutput("empty_frame_drain", swap_req, 0);
        tick(1);
        checkOutput("empty_frame_swap_req", swap_req, 1);
        frame_ready = 1'b0;
        swap_ack = 1'b1;
        tick(1);
        swap_ack = 1'b0;
        checkOutput("empty_frame_done", frame_done, 1);
        checkOutput("empty_frame_count", frame_tri_count, 0);

        $display("[TB] reset during swap and mid-frame");
        frame_ready = 1'b1;
        tick(2);
        checkOutput("pre_reset_swap_req", swap_req, 1);
        applyReset(1);
        checkOutput("reset_swap_req", swap_req, 0);
        checkOutput("reset_swap_occ", occupancy, 0);
        tri_ready = 1'b0;
        sendTriangle(randTri());
        sendTriangle(randTri());
        tick(1);
        checkOutput("reset_pre_occ", occupancy, 2);
        applyReset(1);
        checkOutput("reset_occupancy", occupancy, 0);
        checkOutput("reset_tri_valid", tri_valid, 0);
        checkOutput("reset_tri_x1", tri_x1, 0);
        tri_ready = 1'b1;
        sendTriangle(randTri());
        waitEmpty();

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
